// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: state encoding, access size/type codes and access legality shared by the LSU.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [2:0] LD_B  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_W  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd4;
    localparam logic [2:0] LD_HU = 3'd5;

    // Load types share the store size code in their low two bits.
    function automatic logic acc_ok(input logic wr, input logic [1:0] sz, input logic [2:0] ty,
                                    input logic [1:0] a);
        logic [1:0] s;
        logic       legal;
        s     = wr ? sz : ty[1:0];
        legal = wr ? (sz != 2'd3) : (ty inside {LD_B, LD_H, LD_W, LD_BU, LD_HU});
        return legal && !(s == SZ_H && a[0]) && !(s == SZ_W && a != 2'd0);
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_extend.sv
// load_extend: selects the byte/half lane of read data and sign- or zero-extends it.
module load_extend
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_ty,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = 8'(rdata >> {addr, 3'b000});
        h      = addr[1] ? rdata[31:16] : rdata[15:0];
        result = load_ty == LD_B  ? {{24{b[7]}}, b}  :
                 load_ty == LD_H  ? {{16{h[15]}}, h} :
                 load_ty == LD_BU ? {24'd0, b}       :
                 load_ty == LD_HU ? {16'd0, h}       : rdata;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store controller bridging core access controls to a req/ack bus,
// with core stall, byte strobes, load extension, misalignment flagging and bus timeout.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  store_sz,
    input  logic [2:0]  load_ty,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic [1:0]         sz_q, sz_d;
    logic [2:0]         ty_q, ty_d;
    logic               we_q, we_d, err_q, err_d;
    logic               req, ok, launch;
    logic [31:0]        ext;

    load_extend u_ext (
        .rdata   (bus_rdata),
        .addr    (addr_q[1:0]),
        .load_ty (ty_q),
        .result  (ext)
    );

    always_comb begin
        req     = mem_rd | mem_wr;
        ok      = acc_ok(mem_wr, store_sz, load_ty, addr[1:0]);
        launch  = state_q == IDLE && req && ok;
        state_d = state_q;
        cnt_d   = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sz_d    = sz_q;
        ty_d    = ty_q;
        we_d    = we_q;
        err_d   = 1'b0;
        ld_d    = ld_q;
        if (launch) begin
            state_d = REQ;
            addr_d  = addr;
            wdata_d = wdata;
            sz_d    = store_sz;
            ty_d    = load_ty;
            we_d    = mem_wr;
        end
        if (state_q == REQ) begin
            cnt_d = cnt_q + 1'b1;
            if (bus_ack) begin
                state_d = DONE;
                ld_d    = we_q ? ld_q : ext;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = DONE;
                err_d   = 1'b1;
                ld_d    = '0;
            end
        end
        // DONE never relaunches: the request still present belongs to the retiring access.
        if (state_q == DONE) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sz_q    <= '0;
            ty_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sz_q    <= sz_d;
            ty_q    <= ty_d;
            we_q    <= we_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
        end
    end

    always_comb begin
        stall        = launch || state_q == REQ;
        misalign_err = state_q == IDLE && req && !ok;
        done         = state_q == DONE;
        bus_err      = err_q;
        bus_req      = state_q == REQ;
        bus_we       = bus_req && we_q;
        bus_addr     = {addr_q[31:2], 2'b00};
        bus_wdata    = sz_q == SZ_B ? {4{wdata_q[7:0]}} :
                       sz_q == SZ_H ? {2{wdata_q[15:0]}} : wdata_q;
        bus_wstrb    = !bus_we      ? 4'b0000 :
                       sz_q == SZ_B ? 4'b0001 << addr_q[1:0] :
                       sz_q == SZ_H ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
        load_data    = ld_q;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized accesses checked against a transaction-level LSU model.
module tb_lsu_ctrl;

    logic        clk = 1'b0, reset = 1'b1;
    logic        mem_rd = 1'b0, mem_wr = 1'b0, bus_ack = 1'b0;
    logic [1:0]  store_sz = '0;
    logic [2:0]  load_ty = '0;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic        stall, done, misalign_err, bus_err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    int          vectors = 0, miscompares = 0;
    logic [31:0] ld_model = '0;
    int          st;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .store_sz(store_sz), .load_ty(load_ty), .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .done(done), .misalign_err(misalign_err),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int acc_bytes(input bit wr, input logic [1:0] sz, input logic [2:0] ty);
        if (wr) return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
        return (ty == 3'd0 || ty == 3'd4) ? 1 : (ty == 3'd1 || ty == 3'd5) ? 2 : ty == 3'd2 ? 4 : 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] rd);
        int n;
        logic [31:0] v;
        n = acc_bytes(1'b0, 2'd0, ty);
        if (n == 4) return rd;
        v = rd >> (8 * (a % 4 / n * n));
        v = v & ((32'd1 << (8 * n)) - 1);
        if (ty < 3'd4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    // Starts and ends just after a rising edge; ack_at outside 0..15 means no ack (timeout).
    task automatic access(input bit wr, input bit rd, input logic [1:0] sz, input logic [2:0] ty,
                          input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                          input logic [31:0] rdat, input bit chain, output int stalls);
        int n;
        bit ok, tmo;
        n      = acc_bytes(wr, sz, ty);
        ok     = (wr || rd) && n != 0 && (a % n) == 0;
        tmo    = ack_at < 0 || ack_at > 15;
        stalls = 0;
        mem_wr = wr; mem_rd = rd; store_sz = sz; load_ty = ty; addr = a; wdata = wd; bus_ack = 0;
        @(negedge clk);
        stalls += int'(stall);
        chk("launch_stall", stall, ok);
        chk("misalign_err", misalign_err, (wr || rd) && !ok);
        if (!ok) begin
            @(posedge clk); #1;
            chk("no_bus_req", bus_req, 0);
            mem_wr = 0; mem_rd = 0;
            return;
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (i == ack_at) begin bus_ack = 1; bus_rdata = rdat; end
            @(negedge clk);
            stalls += int'(stall);
            chk("req_bus_req", bus_req, 1);
            chk("req_stall", stall, 1);
            chk("req_we", bus_we, wr);
            chk("req_addr", bus_addr, a & ~32'd3);
            chk("req_wstrb", bus_wstrb, wr ? ((32'd1 << n) - 1) << (a % 4 / n * n) : 0);
            if (wr) chk("req_wdata", bus_wdata, n == 1 ? wd[7:0] * 32'h01010101 :
                                                n == 2 ? wd[15:0] * 32'h00010001 : wd);
            if (i == ack_at) break;
        end
        if (tmo) ld_model = 0;
        else if (!wr) ld_model = exp_load(ty, a, rdat);
        @(posedge clk); #1;
        bus_ack = tmo;
        bus_rdata = $urandom;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_stall", stall, 0);
        chk("done_bus_req", bus_req, 0);
        chk("done_bus_err", bus_err, tmo);
        chk("done_load_data", load_data, ld_model);
        @(posedge clk); #1;
        bus_ack = 0;
        if (chain) return;
        mem_wr = 0; mem_rd = 0;
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_bus_req", bus_req, 0);
        chk("idle_bus_err", bus_err, 0);
        chk("idle_load_data", load_data, ld_model);
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_wstrb", bus_wstrb, 0);
        chk("rst_load_data", load_data, 0);
        @(negedge clk); reset = 0;
        @(posedge clk); #1;

        access(0, 1, 0, 3'd2, 32'h100, 0, 0, 32'hDEADBEEF, 0, st);
        chk("lw_stall_cycles", st, 2);
        chk("lw_data", load_data, 32'hDEADBEEF);

        access(0, 1, 0, 3'd0, 32'h103, 0, 1, 32'h80FFFF7F, 0, st);
        chk("lb_data", load_data, 32'hFFFFFF80);
        access(0, 1, 0, 3'd4, 32'h103, 0, 0, 32'h80FFFF7F, 0, st);
        chk("lbu_data", load_data, 32'h00000080);
        access(0, 1, 0, 3'd5, 32'h102, 0, 2, 32'h80FFFF7F, 0, st);
        chk("lhu_data", load_data, 32'h000080FF);

        access(1, 0, 2'd1, 0, 32'h22, 32'h1234ABCD, 0, 0, 0, st);
        chk("sh_keeps_load_data", load_data, 32'h000080FF);

        access(1, 0, 2'd2, 0, 32'h41, 32'h55, 0, 0, 0, st);
        access(0, 1, 0, 3'd3, 32'h100, 0, 0, 0, 0, st);
        access(1, 1, 2'd3, 3'd2, 32'h100, 0, 0, 0, 0, st);

        access(0, 1, 0, 3'd2, 32'h200, 0, -1, 0, 0, st);
        chk("timeout_stall_cycles", st, 17);

        mem_rd = 1; load_ty = 3'd2; addr = 32'h300;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_req_up", bus_req, 1);
        reset = 1; mem_rd = 0;
        #1;
        chk("async_bus_req", bus_req, 0);
        chk("async_stall", stall, 0);
        ld_model = 0;
        @(negedge clk); reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 0);
        end
        @(posedge clk); #1;

        access(1, 0, 2'd2, 0, 32'h40, 32'hCAFEF00D, 0, 0, 1, st);
        access(0, 1, 0, 3'd2, 32'h44, 0, 0, 32'h01234567, 0, st);
        chk("b2b_data", load_data, 32'h01234567);

        repeat (150) begin
            int k;
            k = $urandom_range(0, 7);
            access(k < 3, k >= 2, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom_range(0, 19), $urandom, 1'($urandom_range(0, 1)), st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
